// File: rtl/comm_code_pkg.sv
// Shared constants, FSM state type and code-bit helper for the K=3, rate-1/2
// convolutional code on the 14-bit-frame Viterbi link.
package comm_code_pkg;

  localparam int K          = 3;
  localparam int INFO_BITS  = 5;
  localparam int TAIL_BITS  = K - 1;
  localparam int FRAME_BITS = 2 * (INFO_BITS + TAIL_BITS);

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Code bit of generator g over the register window {u, s1, s2}.
  function automatic logic code_bit(input logic [K-1:0] g, input logic [K-1:0] win);
    return ^(g & win);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Two-bit trellis state plus c0/c1 generation; also used by the decoder's
// re-encode check path.
module conv_enc_core
  import comm_code_pkg::*;
(
  input  logic clk1,
  input  logic reset,
  input  logic clr,
  input  logic step,
  input  logic u,
  output logic c0,
  output logic c1
);

  logic         s1;
  logic         s2;
  logic [K-1:0] win;

  // clr shows the zero state to c0/c1 in the same cycle it clears the register,
  // so the first code bit of a frame can be produced on the load edge.
  always_comb begin
    win = {u, s1, s2};
    if (clr) begin
      win = {u, 1'b0, 1'b0};
    end else begin
      win = {u, s1, s2};
    end
  end

  assign c0 = code_bit(G0, win);
  assign c1 = code_bit(G1, win);

  // Trellis state register; clr has priority so every frame starts in state 00.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (step) begin
      s1 <= u;
      s2 <= s1;
    end else begin
      s1 <= s1;
      s2 <= s2;
    end
  end

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame-level transmit encoder: holding register, frame shift register, bit
// counter and FSM around conv_enc_core, emitting one code bit per clk1.
module conv_frame_encoder
  import comm_code_pkg::*;
(
  input  logic                 clk1,
  input  logic                 reset,
  input  logic                 din_valid,
  input  logic [INFO_BITS-1:0] din,
  output logic                 din_ready,
  output logic                 tx_valid,
  output logic                 tx_bit,
  output logic                 frame_start,
  output logic [7:0]           frame_cnt
);

  localparam int               CNT_W    = $clog2(FRAME_BITS);
  localparam int               SH_W     = INFO_BITS + TAIL_BITS;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t               state;
  logic                 hold_full;
  logic [INFO_BITS-1:0] hold;
  logic [SH_W-1:0]      shreg;
  logic [CNT_W-1:0]     bit_cnt;

  logic accept;
  logic at_last;
  logic load;
  logic enc_clr;
  logic enc_step;
  logic enc_u;
  logic c0;
  logic c1;

  assign din_ready = ~hold_full;
  assign accept    = din_valid & ~hold_full;
  assign at_last   = (state == RUN) && (bit_cnt == LAST_BIT);

  // Next-bit control: bit_cnt names the bit on the line, the core computes the
  // following one. The state steps on the edge that emits c1 of a pair.
  always_comb begin
    load     = 1'b0;
    enc_clr  = 1'b0;
    enc_step = 1'b0;
    enc_u    = 1'b0;
    case (state)
      IDLE: begin
        load    = hold_full;
        enc_clr = hold_full;
        enc_u   = hold[INFO_BITS-1];
      end
      RUN: begin
        if (at_last) begin
          load    = hold_full;
          enc_clr = hold_full;
          enc_u   = hold[INFO_BITS-1];
        end else begin
          enc_u    = shreg[SH_W-1];
          enc_step = ~bit_cnt[0];
        end
      end
      default: begin
        load     = 1'b0;
        enc_clr  = 1'b0;
        enc_step = 1'b0;
        enc_u    = 1'b0;
      end
    endcase
  end

  conv_enc_core u_core (
    .clk1  (clk1),
    .reset (reset),
    .clr   (enc_clr),
    .step  (enc_step),
    .u     (enc_u),
    .c0    (c0),
    .c1    (c1)
  );

  // Single-entry holding register between the word interface and the framer.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold      <= {INFO_BITS{1'b0}};
    end else if (accept) begin
      hold_full <= 1'b1;
      hold      <= din;
    end else if (load) begin
      hold_full <= 1'b0;
      hold      <= hold;
    end else begin
      hold_full <= hold_full;
      hold      <= hold;
    end
  end

  // Framer FSM with registered line outputs; a reload at bit 13 keeps tx_valid high.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= {CNT_W{1'b0}};
      shreg       <= {SH_W{1'b0}};
      tx_valid    <= 1'b0;
      tx_bit      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_start <= load;
      if (load) begin
        state    <= RUN;
        bit_cnt  <= {CNT_W{1'b0}};
        shreg    <= {hold, {TAIL_BITS{1'b0}}};
        tx_valid <= 1'b1;
        tx_bit   <= c0;
      end else if ((state == RUN) && !at_last) begin
        state    <= RUN;
        bit_cnt  <= bit_cnt + CNT_W'(1'b1);
        shreg    <= enc_step ? {shreg[SH_W-2:0], 1'b0} : shreg;
        tx_valid <= 1'b1;
        tx_bit   <= bit_cnt[0] ? c0 : c1;
      end else begin
        state    <= IDLE;
        bit_cnt  <= {CNT_W{1'b0}};
        shreg    <= shreg;
        tx_valid <= 1'b0;
        tx_bit   <= 1'b0;
      end
      if (at_last) begin
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed bench for conv_frame_encoder: known codewords, framing timing,
// back-to-back reloads, mid-frame reset and brute-force ML loopback decoding.
module tb_conv_frame_encoder;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       din_valid;
  logic [4:0] din;
  logic       din_ready;
  logic       tx_valid;
  logic       tx_bit;
  logic       frame_start;
  logic [7:0] frame_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_cyc      = 0;

  bit rx_q[$];
  bit fs_q[$];
  bit dr_q[$];
  int cyc_q[$];

  conv_frame_encoder dut (
    .clk1        (clk1),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready),
    .tx_valid    (tx_valid),
    .tx_bit      (tx_bit),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Line monitor: record every valid code bit with its framing context.
  always @(negedge clk1) begin
    if (tx_valid === 1'b1) begin
      rx_q.push_back(tx_bit);
      fs_q.push_back(frame_start);
      dr_q.push_back(din_ready);
      cyc_q.push_back(cyc);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoder written straight from the generator polynomials.
  function automatic logic [13:0] enc_model(input logic [4:0] w);
    logic a, b, u;
    logic [13:0] r;
    a = 1'b0; b = 1'b0; r = 14'h0000;
    for (int k = 0; k < 7; k++) begin
      u = (k < 5) ? w[4-k] : 1'b0;
      r[2*k]   = u ^ a ^ b;
      r[2*k+1] = u ^ b;
      b = a;
      a = u;
    end
    return r;
  endfunction

  function automatic logic [4:0] ml_decode(input logic [13:0] cw);
    int best_d = 99;
    logic [4:0] best = 5'h00;
    for (int w = 0; w < 32; w++) begin
      int d;
      d = $countones(enc_model(5'(w)) ^ cw);
      if (d < best_d) begin
        best_d = d;
        best   = 5'(w);
      end
    end
    return best;
  endfunction

  function automatic logic [13:0] frame_at(input int start);
    logic [13:0] r = 14'h0000;
    for (int i = 0; i < 14; i++) r[i] = rx_q[start+i];
    return r;
  endfunction

  function automatic int count_fs();
    int n = 0;
    foreach (fs_q[i]) n += int'(fs_q[i]);
    return n;
  endfunction

  task automatic clear_mon();
    rx_q.delete(); fs_q.delete(); dr_q.delete(); cyc_q.delete();
  endtask

  task automatic send_word(input logic [4:0] w);
    int budget = 0;
    @(negedge clk1);
    din = w; din_valid = 1'b1;
    while (din_ready !== 1'b1 && budget < 100) begin
      @(negedge clk1);
      budget++;
    end
    tests_run++;
    if (budget >= 100) begin
      tests_failed++;
      $display("FAIL send_timeout: din_ready=%b required 1 within 100 cycles", din_ready);
    end
    @(posedge clk1);
    #1;
    acc_cyc = cyc; din_valid = 1'b0; din = ~w;
  endtask

  task automatic test_reset();
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    tests_run++; if (tx_bit !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_bit: got %b want 0", tx_bit); end
    tests_run++; if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    tests_run++; if (frame_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    tests_run++; if (din_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
  endtask

  task automatic test_single();
    clear_mon();
    send_word(5'b10000);
    repeat (20) @(negedge clk1);
    tests_run++; if (rx_q.size() != 14) begin tests_failed++; $display("FAIL single_len: got %0d bits want 14", rx_q.size()); end
    if (rx_q.size() == 14) begin
      tests_run++; if (frame_at(0) !== 14'h0037) begin tests_failed++; $display("FAIL single_code: got %h want 0037", frame_at(0)); end
      tests_run++; if (count_fs() != 1 || fs_q[0] !== 1'b1) begin tests_failed++; $display("FAIL single_frame_start: got %0d pulses (first %b) want 1 at bit0", count_fs(), fs_q[0]); end
      tests_run++; if (cyc_q[0] != acc_cyc + 1) begin tests_failed++; $display("FAIL single_latency: bit0 at cycle %0d want %0d", cyc_q[0], acc_cyc + 1); end
      tests_run++; if (cyc_q[13] - cyc_q[0] != 13) begin tests_failed++; $display("FAIL single_gapless: span %0d want 13", cyc_q[13] - cyc_q[0]); end
    end
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle: tx_valid=%b want 0", tx_valid); end
    tests_run++; if (frame_cnt !== 8'd1) begin tests_failed++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_all_ones();
    logic [6:0] ans;
    clear_mon();
    send_word(5'b11111);
    repeat (20) @(negedge clk1);
    tests_run++; if (rx_q.size() != 14) begin tests_failed++; $display("FAIL ones_len: got %0d bits want 14", rx_q.size()); end
    if (rx_q.size() == 14) begin
      tests_run++; if (frame_at(0) !== 14'h395B) begin tests_failed++; $display("FAIL ones_code: got %h want 395b", frame_at(0)); end
      ans = {ml_decode(frame_at(0)), 2'b00};
      tests_run++; if (ans !== 7'b1111100) begin tests_failed++; $display("FAIL ones_loopback: got %b want 1111100", ans); end
    end
    tests_run++; if (frame_cnt !== 8'd2) begin tests_failed++; $display("FAIL ones_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] wa, wb;
    wa = 5'b10110; wb = 5'b01101;
    clear_mon();
    send_word(wa);
    send_word(wb);
    tests_run++; if (din_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_after_accept: got %b want 0", din_ready); end
    repeat (35) @(negedge clk1);
    tests_run++; if (rx_q.size() != 28) begin tests_failed++; $display("FAIL b2b_len: got %0d bits want 28", rx_q.size()); end
    if (rx_q.size() == 28) begin
      tests_run++; if (frame_at(0) !== enc_model(wa)) begin tests_failed++; $display("FAIL b2b_frame0: got %h want %h", frame_at(0), enc_model(wa)); end
      tests_run++; if (frame_at(14) !== enc_model(wb)) begin tests_failed++; $display("FAIL b2b_frame1: got %h want %h", frame_at(14), enc_model(wb)); end
      tests_run++; if (cyc_q[27] - cyc_q[0] != 27) begin tests_failed++; $display("FAIL b2b_gapless: span %0d want 27", cyc_q[27] - cyc_q[0]); end
      tests_run++; if (count_fs() != 2 || fs_q[0] !== 1'b1 || fs_q[14] !== 1'b1) begin tests_failed++; $display("FAIL b2b_frame_start: got %0d pulses want 2 at bits 0 and 14", count_fs()); end
      tests_run++; if (dr_q[13] !== 1'b0 || dr_q[14] !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b%b at bits 13/14 want 01", dr_q[13], dr_q[14]); end
    end
    tests_run++; if (frame_cnt !== 8'd4) begin tests_failed++; $display("FAIL b2b_frame_cnt: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_reload_accept();
    logic [4:0] wa, wb, wc;
    wa = 5'b00001; wb = 5'b11010; wc = 5'b10101;
    clear_mon();
    send_word(wa);
    repeat (14) @(negedge clk1);
    send_word(wb);
    send_word(wc);
    repeat (40) @(negedge clk1);
    tests_run++; if (rx_q.size() != 42) begin tests_failed++; $display("FAIL reload_len: got %0d bits want 42", rx_q.size()); end
    if (rx_q.size() == 42) begin
      tests_run++; if (frame_at(0) !== enc_model(wa)) begin tests_failed++; $display("FAIL reload_frame0: got %h want %h", frame_at(0), enc_model(wa)); end
      tests_run++; if (frame_at(14) !== enc_model(wb)) begin tests_failed++; $display("FAIL reload_frame1: got %h want %h", frame_at(14), enc_model(wb)); end
      tests_run++; if (frame_at(28) !== enc_model(wc)) begin tests_failed++; $display("FAIL reload_frame2: got %h want %h", frame_at(28), enc_model(wc)); end
      tests_run++; if (cyc_q[14] - cyc_q[13] != 2) begin tests_failed++; $display("FAIL reload_idle_gap: got %0d want 2", cyc_q[14] - cyc_q[13]); end
      tests_run++; if (cyc_q[41] - cyc_q[14] != 27) begin tests_failed++; $display("FAIL reload_gapless: span %0d want 27", cyc_q[41] - cyc_q[14]); end
      tests_run++; if (count_fs() != 3) begin tests_failed++; $display("FAIL reload_frame_start: got %0d pulses want 3", count_fs()); end
    end
    tests_run++; if (frame_cnt !== 8'd7) begin tests_failed++; $display("FAIL reload_frame_cnt: got %0d want 7", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    send_word(5'b11111);
    repeat (8) @(negedge clk1);
    tests_run++; if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_running: tx_valid=%b want 1 at bit 6", tx_valid); end
    reset = 1'b0;
    #1;
    tests_run++; if ({tx_valid, tx_bit, frame_start} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_outputs: got %b want 000", {tx_valid, tx_bit, frame_start}); end
    tests_run++; if (frame_cnt !== 8'd0) begin tests_failed++; $display("FAIL rstmid_frame_cnt: got %0d want 0", frame_cnt); end
    tests_run++; if (din_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_din_ready: got %b want 1", din_ready); end
    repeat (2) @(negedge clk1);
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_hold_low: tx_valid=%b want 0", tx_valid); end
    reset = 1'b1;
    clear_mon();
    send_word(5'b10000);
    repeat (20) @(negedge clk1);
    tests_run++; if (rx_q.size() != 14) begin tests_failed++; $display("FAIL rstmid_len: got %0d bits want 14", rx_q.size()); end
    if (rx_q.size() == 14) begin
      tests_run++; if (frame_at(0) !== 14'h0037) begin tests_failed++; $display("FAIL rstmid_code: got %h want 0037", frame_at(0)); end
      tests_run++; if (fs_q[0] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_frame_start: got %b want 1", fs_q[0]); end
    end
    tests_run++; if (frame_cnt !== 8'd1) begin tests_failed++; $display("FAIL rstmid_frame_cnt_after: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_random();
    logic [4:0]  words[$];
    int          errpos[$];
    logic [13:0] cw;
    logic [4:0]  dec;
    clear_mon();
    for (int i = 0; i < 200; i++) begin
      logic [4:0] w;
      w = 5'($urandom_range(0, 31));
      words.push_back(w);
      errpos.push_back(int'($urandom_range(0, 14)));
      send_word(w);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 20)) @(negedge clk1);
    end
    repeat (40) @(negedge clk1);
    tests_run++; if (rx_q.size() != 2800) begin tests_failed++; $display("FAIL rand_len: got %0d bits want 2800", rx_q.size()); end
    if (rx_q.size() == 2800) begin
      for (int f = 0; f < 200; f++) begin
        cw = frame_at(14 * f);
        tests_run++; if (cw !== enc_model(words[f])) begin tests_failed++; $display("FAIL rand_code[%0d]: got %h want %h", f, cw, enc_model(words[f])); end
        if (errpos[f] < 14) cw[errpos[f]] = ~cw[errpos[f]];
        dec = ml_decode(cw);
        tests_run++; if (dec !== words[f]) begin tests_failed++; $display("FAIL rand_decode[%0d]: got %b want %b (err at %0d)", f, dec, words[f], errpos[f]); end
      end
    end
    tests_run++; if (frame_cnt !== 8'd201) begin tests_failed++; $display("FAIL rand_frame_cnt: got %0d want 201", frame_cnt); end
  endtask

  initial begin
    reset = 1'b0; din_valid = 1'b0; din = 5'h00;
    repeat (3) @(negedge clk1);
    test_reset();
    @(negedge clk1);
    reset = 1'b1;
    test_single();
    test_all_ones();
    test_back_to_back();
    test_reload_accept();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
